// File: rtl/mux4_rr_sched.sv
// ============================================================================
// mux4_rr_sched
// ----------------------------------------------------------------------------
// Round-robin scheduler that sits in front of the shared 4:1 2-bit select mux.
// It picks one of four requesters, drives the mux select and a one-hot grant,
// and counts accepted beats against the downstream ready. A grant ends when
// the granted requester drops its request or when it has transferred
// BURST_MAX beats. The scheduler then re-arbitrates on the same edge, so
// there is no idle bubble between back-to-back bursts.
//
// Parameters
//   BURST_MAX : maximum accepted beats per grant (1..15)
//   CNT_W     : beat counter width, must be able to hold BURST_MAX
//
// Ports
//   clk     in   1  system clock, all state updates on the rising edge
//   rstn    in   1  synchronous active-low reset
//   req     in   4  request per requester, held high while it has data
//   dst_rdy in   1  downstream accepts the mux output this cycle
//   sel     out  2  registered mux select, index of the granted requester
//   gnt     out  4  registered one-hot grant, all-zero when idle
//   beat    out  1  combinational transfer strobe: busy & req[sel] & dst_rdy
//   busy    out  1  registered, a grant is active
// ============================================================================
module mux4_rr_sched #(
    parameter int BURST_MAX = 4,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] req,
    input  logic       dst_rdy,
    output logic [1:0] sel,
    output logic [3:0] gnt,
    output logic       beat,
    output logic       busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);

    state_t           state_q, state_d;
    logic [1:0]       sel_q,   sel_d;
    logic [3:0]       gnt_q,   gnt_d;
    logic             busy_q,  busy_d;
    logic [1:0]       ptr_q,   ptr_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic       any_req;
    logic [1:0] arb_base;
    logic [1:0] winner;
    logic       release_grant;

    // Pick the first set request starting one past 'last', with wrap.
    // Iterating from the lowest priority offset down to the highest means
    // the last assignment that hits is the highest-priority requester, and
    // 'last' itself (offset 4, i.e. 0) ends up lowest priority.
    function automatic logic [1:0] rr_pick(input logic [3:0] r,
                                           input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] pick;
        pick = last;
        for (int i = 4; i >= 1; i--) begin
            idx = last + i[1:0];
            if (r[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

    assign beat    = busy_q & req[sel_q] & dst_rdy;
    assign any_req = |req;

    // While granted the pointer always equals sel, but re-arbitration is
    // defined relative to the current select, so use it directly there.
    assign arb_base = (state_q == GRANT) ? sel_q : ptr_q;
    assign winner   = rr_pick(req, arb_base);

    // A requester dropping req and the last beat of a burst can coincide;
    // either one ends the grant and they collapse into a single release.
    assign release_grant = (state_q == GRANT) &&
                           (!req[sel_q] || (beat && (cnt_q == CNT_LAST)));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            gnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            ptr_q   <= 2'd3;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                gnt_d  = 4'd0;
                busy_d = 1'b0;
                if (any_req) begin
                    state_d = GRANT;
                    sel_d   = winner;
                    gnt_d   = 4'b0001 << winner;
                    busy_d  = 1'b1;
                    ptr_d   = winner;
                    cnt_d   = '0;
                end
            end

            GRANT: begin
                if (release_grant) begin
                    // A lone requester that just hit the burst limit wins
                    // again here and simply starts a fresh burst.
                    if (any_req) begin
                        state_d = GRANT;
                        sel_d   = winner;
                        gnt_d   = 4'b0001 << winner;
                        busy_d  = 1'b1;
                        ptr_d   = winner;
                        cnt_d   = '0;
                    end else begin
                        // sel keeps its last value while idle.
                        state_d = IDLE;
                        gnt_d   = 4'd0;
                        busy_d  = 1'b0;
                        cnt_d   = '0;
                    end
                end else if (beat) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sel  = sel_q;
    assign gnt  = gnt_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_mux4_rr_sched.sv
// ============================================================================
// tb_mux4_rr_sched
// ----------------------------------------------------------------------------
// Directed testbench for mux4_rr_sched. Two instances share the stimulus:
// dut uses BURST_MAX=4 and dut1 uses BURST_MAX=1 for per-beat round-robin.
// Inputs change 1 time unit after a rising edge; registered outputs are
// checked 1 unit after the edge and beat is checked before the next edge.
// ============================================================================
module tb_mux4_rr_sched;

    logic       clk;
    logic       rstn;
    logic [3:0] req;
    logic       dst_rdy;

    logic [1:0] sel,  sel1;
    logic [3:0] gnt,  gnt1;
    logic       beat, beat1;
    logic       busy, busy1;

    int checkCount;
    int errorCount;

    mux4_rr_sched #(.BURST_MAX(4), .CNT_W(4)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .req     (req),
        .dst_rdy (dst_rdy),
        .sel     (sel),
        .gnt     (gnt),
        .beat    (beat),
        .busy    (busy)
    );

    mux4_rr_sched #(.BURST_MAX(1), .CNT_W(4)) dut1 (
        .clk     (clk),
        .rstn    (rstn),
        .req     (req),
        .dst_rdy (dst_rdy),
        .sel     (sel1),
        .gnt     (gnt1),
        .beat    (beat1),
        .busy    (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it when the observed value differs.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic d);
        req     = r;
        dst_rdy = d;
        #1;
    endtask

    task automatic applyReset();
        rstn    = 1'b0;
        req     = 4'd0;
        dst_rdy = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    int grantSeq [5] = '{0, 1, 2, 3, 0};

    initial begin
        checkCount = 0;
        errorCount = 0;
        rstn       = 1'b0;
        req        = 4'd0;
        dst_rdy    = 1'b0;

        // ---- Reset values and idle with no requests -------------------------
        applyReset();
        #1;
        checkOutput("rst_gnt",  32'(gnt),  32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_sel",  32'(sel),  32'h0);
        checkOutput("rst_beat", 32'(beat), 32'h0);
        for (int c = 0; c < 5; c++) begin
            applyStimulus(4'b0000, 1'b1);
            checkOutput("idle_beat", 32'(beat), 32'h0);
            tick();
            checkOutput("idle_gnt",  32'(gnt),  32'h0);
            checkOutput("idle_busy", 32'(busy), 32'h0);
            checkOutput("idle_sel",  32'(sel),  32'h0);
        end
        applyStimulus(4'b0001, 1'b0);
        checkOutput("lat_gnt_pre", 32'(gnt), 32'h0);
        tick();
        checkOutput("lat_gnt",  32'(gnt),  32'h1);
        checkOutput("lat_sel",  32'(sel),  32'h0);
        checkOutput("lat_busy", 32'(busy), 32'h1);
        applyStimulus(4'b0000, 1'b0);
        tick();
        checkOutput("drop_idle_gnt",  32'(gnt),  32'h0);
        checkOutput("drop_idle_busy", 32'(busy), 32'h0);
        checkOutput("drop_idle_sel",  32'(sel),  32'h0);

        // ---- All four requesting: 4-beat bursts, no idle gap ---------------
        applyReset();
        applyStimulus(4'b1111, 1'b1);
        tick();
        for (int g = 0; g < 5; g++) begin
            for (int k = 0; k < 4; k++) begin
                checkOutput("rr_gnt",  32'(gnt),  32'(4'b0001 << grantSeq[g]));
                checkOutput("rr_sel",  32'(sel),  32'(grantSeq[g]));
                checkOutput("rr_busy", 32'(busy), 32'h1);
                checkOutput("rr_beat", 32'(beat), 32'h1);
                tick();
            end
        end

        // ---- Single requester with stalls, then a fresh burst --------------
        applyReset();
        applyStimulus(4'b0100, 1'b0);
        tick();
        checkOutput("stall_gnt0", 32'(gnt), 32'h4);
        for (int c = 0; c < 7; c++) begin
            applyStimulus(4'b0100, (c % 2) == 0);
            checkOutput("stall_beat", 32'(beat), 32'((c % 2) == 0));
            tick();
            checkOutput("stall_gnt", 32'(gnt), 32'h4);
            checkOutput("stall_sel", 32'(sel), 32'h2);
        end
        // Re-granted with cnt=0: three more beats keep the grant, the fourth
        // releases towards requester 1.
        for (int c = 0; c < 3; c++) begin
            applyStimulus(4'b0110, 1'b1);
            tick();
            checkOutput("fresh_gnt_hold", 32'(gnt), 32'h4);
        end
        applyStimulus(4'b0110, 1'b1);
        tick();
        checkOutput("fresh_gnt_next", 32'(gnt), 32'h2);
        checkOutput("fresh_sel_next", 32'(sel), 32'h1);

        // ---- Granted requester drops mid-burst -----------------------------
        applyReset();
        applyStimulus(4'b1010, 1'b1);
        tick();
        checkOutput("drop_gnt1", 32'(gnt), 32'h2);
        for (int c = 0; c < 2; c++) begin
            checkOutput("drop_beat1", 32'(beat), 32'h1);
            tick();
        end
        checkOutput("drop_gnt1_held", 32'(gnt), 32'h2);
        applyStimulus(4'b1000, 1'b1);
        checkOutput("drop_beat0", 32'(beat), 32'h0);
        tick();
        checkOutput("drop_gnt3", 32'(gnt), 32'h8);
        checkOutput("drop_sel3", 32'(sel), 32'h3);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(4'b1010, 1'b1);
            tick();
            checkOutput("drop_gnt3_hold", 32'(gnt), 32'h8);
        end
        tick();
        checkOutput("drop_gnt1_again", 32'(gnt), 32'h2);

        // ---- Reset in the middle of a burst --------------------------------
        applyReset();
        applyStimulus(4'b0011, 1'b1);
        tick();
        checkOutput("mid_gnt0", 32'(gnt), 32'h1);
        for (int c = 0; c < 4; c++) begin
            tick();
        end
        checkOutput("mid_gnt1", 32'(gnt), 32'h2);
        tick();
        rstn = 1'b0;
        tick();
        checkOutput("mid_rst_gnt",  32'(gnt),  32'h0);
        checkOutput("mid_rst_busy", 32'(busy), 32'h0);
        checkOutput("mid_rst_sel",  32'(sel),  32'h0);
        rstn = 1'b1;
        applyStimulus(4'b0011, 1'b1);
        checkOutput("mid_rst_beat", 32'(beat), 32'h0);
        tick();
        checkOutput("mid_regnt", 32'(gnt), 32'h1);
        checkOutput("mid_resel", 32'(sel), 32'h0);

        // ---- BURST_MAX=1: per-beat alternation between 1 and 3 -------------
        applyReset();
        applyStimulus(4'b1010, 1'b1);
        tick();
        for (int c = 0; c < 6; c++) begin
            checkOutput("bm1_sel",  32'(sel1),  32'(((c % 2) == 0) ? 1 : 3));
            checkOutput("bm1_gnt",  32'(gnt1),  32'(((c % 2) == 0) ? 4'b0010 : 4'b1000));
            checkOutput("bm1_beat", 32'(beat1), 32'h1);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/mux4_rr_sched.md
Name: mux4_rr_sched

Overview:
- Round-robin scheduler that shares the team's 4:1 2-bit select mux between four requesters.
- Drives the mux select and a one-hot grant vector.
- Counts accepted beats per grant against a downstream ready signal, and caps each grant at a burst limit.
- Sits directly in front of the mux; requesters present data on p0..p3, and the mux output goes to a single downstream consumer.

Parameters:
- BURST_MAX, 4, maximum accepted beats per grant; legal range 1..15.
- CNT_W, 4, beat counter width; must hold BURST_MAX.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rstn  in  1  synchronous active-low reset; sampled on rising edge of clk
- req  in  4  request per requester; req[i] held high while requester i has data
- dst_rdy  in  1  downstream accepts the mux output this cycle
- sel  out  2  mux select; registered; equals index of granted requester
- gnt  out  4  one-hot grant; registered; all-zero when idle
- beat  out  1  transfer this cycle; combinational: busy & req[sel] & dst_rdy
- busy  out  1  a grant is active; registered

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous and active-low: rstn=0 at a rising edge of clk forces reset state regardless of current state, including mid-burst.
- Reset values:
  - sel=0, gnt=0, busy=0, beat=0.
  - Internal last-winner pointer ptr=3, so requester 0 has first priority.
  - Beat counter=0, FSM=IDLE.
- States: IDLE, GRANT.
- Arbitration function:
  - Search req starting at index (ptr+1) mod 4, ascending with wrap.
  - The first set bit wins.
  - The current winner is therefore always lowest priority.
- IDLE:
  - If req!=0 at an edge, register the winner: sel=winner, gnt=1<<winner, busy=1, ptr=winner, cnt=0, go to GRANT.
  - Latency: req rising at cycle n gives gnt at cycle n+1.
  - If req=0, stay in IDLE with gnt=0.
- GRANT:
  - beat=1 when req[sel]&dst_rdy. Each beat increments cnt at the edge.
  - Release condition at an edge: req[sel]=0, or (beat=1 and cnt==BURST_MAX-1).
  - Both conditions true at the same edge count as a single release.
  - On release, re-arbitrate at the same edge using the current req and ptr=sel.
    - If any req bit is set, grant the new winner directly, with no idle bubble, and reset cnt to 0.
    - Otherwise go to IDLE: gnt=0, busy=0, sel holds its last value.
  - If the same requester is the only one requesting after hitting BURST_MAX, it is re-granted a fresh burst with cnt=0.
  - No release: hold sel/gnt. If dst_rdy=0, cnt holds (stall), with no limit on stall length.
  - A requester dropping req while granted: beat=0 that cycle, release at that edge.
  - req bits of non-granted requesters changing mid-burst have no effect until the next release.
- BURST_MAX=1: every beat releases and re-arbitrates, giving strict per-beat round-robin.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt[sel]==busy.
  - sel only changes at a grant.
  - cnt never exceeds BURST_MAX-1.

Test Plan:
- Reset then req=4'b0000 for 5 cycles -> gnt=0, busy=0, sel=0, beat=0 throughout; then req=4'b0001 -> gnt=4'b0001, sel=0 exactly one cycle later.
- BURST_MAX=4, req=4'b1111 held, dst_rdy=1 -> grants 0,1,2,3,0 in turn, 4 beats each, and gnt switches with no idle cycle between bursts.
- req=4'b0100 only, dst_rdy toggling 1,0,1,0 -> beat follows dst_rdy. Grant to 2 persists through stalls; release after 4th accepted beat, then immediate re-grant to 2 with cnt=0.
- Granted requester 1 drops req after 2 beats while req[3]=1 -> at that edge gnt=4'b1000, sel=3; 1 is not regranted before 3.
- req=4'b0011, rstn pulled low for one cycle mid-burst of requester 1 -> next cycle gnt=0, busy=0, sel=0; then requester 0 wins first (ptr reset to 3).
- BURST_MAX=1, req=4'b1010, dst_rdy=1 -> sel alternates 1,3,1,3 each cycle with beat=1 every cycle.
